// File: rtl/rca_bist_checker_if.sv
// Adder-under-test bus: operands driven by the checker, results returned by the adder.
interface rca_bist_checker_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (
    output dut_a, dut_b, dut_cin,
    input  dut_sum, dut_cout
  );

  modport slave (
    input  dut_a, dut_b, dut_cin,
    output dut_sum, dut_cout
  );
endinterface

// File: rtl/rca_bist_checker.sv
// Exhaustive BIST checker for a WIDTH-bit adder with LAT-cycle result latency:
// drives every {a,b,cin}, compares against a delayed golden sum, logs faults.
module rca_bist_checker #(
  parameter int WIDTH = 2,
  parameter int LAT   = 1,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop_on_fail,
  rca_bist_checker_if.master   adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WIDTH:0]       fault_mask,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH:0]     first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned PD = (LAT > 0) ? LAT : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic [VW-1:0]   drv_q;
  logic [1:0]      dcnt_q, dcnt_d;
  logic            stop_q;
  logic            clr, flush;

  logic [WIDTH:0]  mask_q;
  logic [ERR_W-1:0] err_q;
  logic [VW-1:0]   ffv_q;
  logic            ffvalid_q;

  logic            in_valid;
  logic [WIDTH:0]  in_exp;
  logic            cmp_valid;
  logic [WIDTH:0]  cmp_exp;
  logic [VW-1:0]   cmp_tag;
  logic [WIDTH:0]  diff;
  logic            mism;

  function automatic logic [WIDTH:0] golden(input logic [VW-1:0] vec);
    return {1'b0, vec[VW-1:WIDTH+1]} + {1'b0, vec[WIDTH:1]} + {{WIDTH{1'b0}}, vec[0]};
  endfunction

  assign in_valid = (state_q == S_RUN);
  assign in_exp   = golden(v_q);

  // Expected/tag delay line; with zero latency the driven vector is compared directly.
  if (LAT > 0) begin : g_pipe
    logic [PD-1:0]            pv_q;
    logic [PD-1:0][WIDTH:0]   pe_q;
    logic [PD-1:0][VW-1:0]    pt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        pe_q <= '0;
        pt_q <= '0;
      end else begin
        pe_q[0] <= in_exp;
        pt_q[0] <= v_q;
        for (int unsigned i = 1; i < PD; i++) begin
          pe_q[i] <= pe_q[i-1];
          pt_q[i] <= pt_q[i-1];
        end
        if (flush || clr) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= in_valid;
          for (int unsigned i = 1; i < PD; i++) pv_q[i] <= pv_q[i-1];
        end
      end
    end

    assign cmp_valid = pv_q[PD-1];
    assign cmp_exp   = pe_q[PD-1];
    assign cmp_tag   = pt_q[PD-1];
  end else begin : g_nopipe
    assign cmp_valid = in_valid;
    assign cmp_exp   = in_exp;
    assign cmp_tag   = v_q;
  end

  assign diff = {adder.dut_cout, adder.dut_sum} ^ cmp_exp;
  assign mism = cmp_valid && busy && (|diff);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    dcnt_d  = dcnt_q;
    clr     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          v_d     = '0;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        v_d = v_q + 1'b1;
        if (v_q == '1) begin
          state_d = (LAT > 0) ? S_DRAIN : S_DONE;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == 2'(LAT - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Early stop overrides normal sequencing and discards in-flight compares.
    if (mism && stop_q) begin
      state_d = S_DONE;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      drv_q   <= '0;
      dcnt_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      drv_q   <= (state_d == S_RUN) ? v_d : '0;
      dcnt_q  <= dcnt_d;
      if (clr) stop_q <= stop_on_fail;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else if (clr) begin
      mask_q    <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else if (mism) begin
      mask_q <= mask_q | diff;
      if (err_q != '1) err_q <= err_q + 1'b1;
      if (!ffvalid_q) begin
        ffv_q     <= cmp_tag;
        ffvalid_q <= 1'b1;
      end
    end
  end

  assign adder.dut_a   = drv_q[VW-1:WIDTH+1];
  assign adder.dut_b   = drv_q[WIDTH:1];
  assign adder.dut_cin = drv_q[0];

  assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign fault_mask       = mask_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_rca_bist_checker.sv
// Directed and randomized fault-injection runs on three checker configurations.
module tb_rca_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stop_on_fail = 1'b0;
  logic [2:0] go = '0;
  logic [4:0] sa0 = '0;
  logic [4:0] sa1 = '0;
  int cur = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_bist_checker_if #(.WIDTH(2)) if0 ();
  rca_bist_checker_if #(.WIDTH(2)) if1 ();
  rca_bist_checker_if #(.WIDTH(4)) if2 ();

  logic       busy0, done0, pass0, ffval0;
  logic [2:0] mask0;
  logic [7:0] err0;
  logic [4:0] ffv0;
  logic       busy1, done1, pass1, ffval1;
  logic [2:0] mask1;
  logic [2:0] err1;
  logic [4:0] ffv1;
  logic       busy2, done2, pass2, ffval2;
  logic [4:0] mask2;
  logic [7:0] err2;
  logic [8:0] ffv2;

  rca_bist_checker #(.WIDTH(2), .LAT(1), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(go[0]), .stop_on_fail(stop_on_fail), .adder(if0),
    .busy(busy0), .done(done0), .pass(pass0), .fault_mask(mask0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  rca_bist_checker #(.WIDTH(2), .LAT(1), .ERR_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(go[1]), .stop_on_fail(stop_on_fail), .adder(if1),
    .busy(busy1), .done(done1), .pass(pass1), .fault_mask(mask1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  rca_bist_checker #(.WIDTH(4), .LAT(0), .ERR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(go[2]), .stop_on_fail(stop_on_fail), .adder(if2),
    .busy(busy2), .done(done2), .pass(pass2), .fault_mask(mask2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_valid(ffval2));

  // Behavioural adders with stuck-at faults: one-cycle registered for u0/u1, combinational for u2.
  logic [2:0] r0, r1;
  always_ff @(posedge clk) begin
    r0 <= ((({1'b0, if0.dut_a} + {1'b0, if0.dut_b} + {2'b0, if0.dut_cin}) & ~sa0[2:0]) | sa1[2:0]);
    r1 <= ((({1'b0, if1.dut_a} + {1'b0, if1.dut_b} + {2'b0, if1.dut_cin}) & ~sa0[2:0]) | sa1[2:0]);
  end
  assign {if0.dut_cout, if0.dut_sum} = r0;
  assign {if1.dut_cout, if1.dut_sum} = r1;
  assign {if2.dut_cout, if2.dut_sum} =
    ((({1'b0, if2.dut_a} + {1'b0, if2.dut_b} + {4'b0, if2.dut_cin}) & ~sa0) | sa1);

  logic       s_busy, s_done, s_pass, s_ffval;
  logic [4:0] s_mask;
  logic [7:0] s_err;
  logic [8:0] s_ffv;
  always_comb begin
    s_busy = busy0; s_done = done0; s_pass = pass0; s_ffval = ffval0;
    s_mask = {2'b0, mask0}; s_err = err0; s_ffv = {4'b0, ffv0};
    if (cur == 1) begin
      s_busy = busy1; s_done = done1; s_pass = pass1; s_ffval = ffval1;
      s_mask = {2'b0, mask1}; s_err = {5'b0, err1}; s_ffv = {4'b0, ffv1};
    end else if (cur == 2) begin
      s_busy = busy2; s_done = done2; s_pass = pass2; s_ffval = ffval2;
      s_mask = mask2; s_err = err2; s_ffv = ffv2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk all vectors in order, apply the fault to a+b+cin, accumulate results.
  task automatic ref_run(input int w, input int lat, input int errw, input bit sof,
                         input logic [4:0] s0, input logic [4:0] s1,
                         output int e_err, output int e_mask, output int e_ffv,
                         output int e_ffval, output int e_busy);
    int nv, first, lim, full;
    nv = 1 << (2 * w + 1);
    lim = (1 << errw) - 1;
    full = (1 << (w + 1)) - 1;
    first = -1;
    e_err = 0;
    e_mask = 0;
    for (int v = 0; v < nv; v++) begin
      int a, b, c, g, f, d;
      a = v >> (w + 1);
      b = (v >> 1) & ((1 << w) - 1);
      c = v & 1;
      g = a + b + c;
      f = ((g & ~int'(s0)) | int'(s1)) & full;
      d = f ^ g;
      if (d != 0) begin
        e_mask |= d;
        e_err++;
        if (first < 0) first = v;
        if (sof) break;
      end
    end
    if (e_err > lim) e_err = lim;
    e_ffval = (first >= 0) ? 1 : 0;
    e_ffv = (first >= 0) ? first : 0;
    e_busy = (sof && first >= 0) ? first + lat + 1 : nv + lat;
  endtask

  task automatic run(input string nm, input int inst, input bit sof,
                     input logic [4:0] s0, input logic [4:0] s1, input bit mid_start);
    int w, lat, errw, e_err, e_mask, e_ffv, e_ffval, e_busy, cnt, n;
    w = (inst == 2) ? 4 : 2;
    lat = (inst == 2) ? 0 : 1;
    errw = (inst == 1) ? 3 : 8;
    ref_run(w, lat, errw, sof, s0, s1, e_err, e_mask, e_ffv, e_ffval, e_busy);
    @(negedge clk);
    cur = inst;
    sa0 = s0;
    sa1 = s1;
    stop_on_fail = sof;
    go[inst] = 1'b1;
    @(posedge clk);
    #1;
    go[inst] = 1'b0;
    cnt = 0;
    n = 0;
    while (!s_done && n < 2000) begin
      if (s_busy) cnt++;
      if (mid_start) go[inst] = (n == 10);
      @(posedge clk);
      #1;
      n++;
    end
    go[inst] = 1'b0;
    check({nm, ".timeout"}, 32'(s_done), 32'd1);
    check({nm, ".busy_cycles"}, 32'(cnt), 32'(e_busy));
    check({nm, ".busy_low"}, 32'(s_busy), 32'd0);
    check({nm, ".pass"}, 32'(s_pass), (e_err == 0) ? 32'd1 : 32'd0);
    check({nm, ".err_count"}, 32'(s_err), 32'(e_err));
    check({nm, ".fault_mask"}, 32'(s_mask), 32'(e_mask));
    check({nm, ".ff_valid"}, 32'(s_ffval), 32'(e_ffval));
    check({nm, ".ff_vec"}, 32'(s_ffv), 32'(e_ffv));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'({busy0, busy1, busy2}), 32'd0);
    check("rst.done", 32'({done0, done1, done2}), 32'd0);
    check("rst.pass", 32'({pass0, pass1, pass2}), 32'd0);
    check("rst.dut0", 32'({if0.dut_a, if0.dut_b, if0.dut_cin}), 32'd0);
    check("rst.err0", 32'(err0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("ideal",     0, 1'b0, 5'b00000, 5'b00000, 1'b0);
    run("sum0_sa0",  0, 1'b0, 5'b00001, 5'b00000, 1'b0);
    run("double",    0, 1'b0, 5'b00010, 5'b00100, 1'b0);
    run("cout_stop", 0, 1'b1, 5'b00000, 5'b00100, 1'b0);
    run("sat_err3",  1, 1'b0, 5'b00001, 5'b00000, 1'b1);
    run("w4_ideal",  2, 1'b0, 5'b00000, 5'b00000, 1'b0);

    // Mid-run asynchronous reset on the 4-bit checker with faults accumulating.
    @(negedge clk);
    cur = 2;
    sa0 = 5'b00001;
    sa1 = '0;
    stop_on_fail = 1'b0;
    go[2] = 1'b1;
    @(posedge clk);
    #1;
    go[2] = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst.busy", 32'(busy2), 32'd0);
    check("mrst.done", 32'(done2), 32'd0);
    check("mrst.err", 32'(err2), 32'd0);
    check("mrst.mask", 32'(mask2), 32'd0);
    check("mrst.ffval", 32'(ffval2), 32'd0);
    check("mrst.dut", 32'({if2.dut_a, if2.dut_b, if2.dut_cin}), 32'd0);
    #2;
    rst_n = 1'b1;
    run("w4_after_rst", 2, 1'b0, 5'b00000, 5'b00000, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int inst;
      logic [4:0] r0m, r1m;
      inst = $urandom_range(0, 2);
      r0m = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
      r1m = 5'($urandom_range(0, 31) & $urandom_range(0, 31) & $urandom_range(0, 31));
      run($sformatf("rand%0d", k), inst, 1'($urandom_range(0, 1)), r0m, r1m, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
